switchbank_poll_sched: RTL and testbench
========================================

Name: switchbank_poll_sched

Overview:
- Round-robin polling controller for NDEV polled input peripherals that share the status/data/ack protocol (a0=1 selects status, a0=0 selects data, ack with a0=0 clears status).
- Walks the devices in turn and reads each status word. When a device's bit 0 is set, it reads the data word, acks the device and queues {device index, data} in a small FIFO.
- The CPU drains the FIFO through a valid/ready port, so the CPU no longer spin-polls each switchbank.

Parameters:
- NDEV, 4, number of polled peripherals (2..16).
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- W, 16, peripheral data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- poll_en  in  1  1 = scheduler runs; 0 = scheduler parks in IDLE.
- dev_rdata  in  NDEV*W  packed device read buses; device i occupies bits [i*W +: W].
- dev_a0  out  1  address bit broadcast to all devices (1 = status, 0 = data).
- dev_ack  out  NDEV  one-hot ack; at most one bit high per cycle.
- out_valid  out  1  FIFO non-empty.
- out_data  out  W  data of the FIFO head entry.
- out_dev  out  $clog2(NDEV)  device index of the FIFO head entry.
- out_ready  in  1  CPU pops the head entry when out_valid && out_ready.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ptr=0, FIFO empty.
  - out_valid=0, fifo_level=0, dev_ack=0, dev_a0=1.
  - Reset mid-operation drops any queued entries and any DATA cycle in progress.
- States: IDLE, STATUS, DATA.
- IDLE: dev_a0=1, dev_ack=0. Moves to STATUS on the next edge if poll_en=1.
- STATUS (one cycle per device visit):
  - Outputs: dev_a0=1, dev_ack=0.
  - Sample st = dev_rdata[ptr*W].
  - st=1 and FIFO not full: go to DATA; ptr holds.
  - st=1 and FIFO full: stay in STATUS; ptr holds; the device is not acked and no data is lost. Polling resumes on the cycle after the FIFO leaves full.
  - st=0: ptr advances (NDEV-1 wraps to 0).
  - poll_en=0: go to IDLE; ptr holds.
- DATA (exactly one cycle):
  - Outputs: dev_a0=0, dev_ack[ptr]=1.
  - At the edge, push {ptr, dev_rdata[ptr*W +: W]} into the FIFO. The device clears its status on the same edge.
  - ptr advances with wrap.
  - Next state is STATUS if poll_en=1, else IDLE. A DATA cycle always completes, even if poll_en falls.
- Ack timing:
  - dev_ack is driven combinationally from state and ptr; it is high only in DATA, for one cycle per transfer.
  - dev_a0 is 0 only in DATA.
- Service latency: a ready device is acked at most 2*NDEV cycles after its status bit rises, while the FIFO is not full.
- FIFO:
  - Registered memory with show-ahead read: out_data/out_dev = mem[rd_ptr], valid whenever fifo_level != 0.
  - Pop when out_valid && out_ready. Pop while empty is ignored.
  - Push occurs only from DATA. Space is guaranteed because fullness was checked in the preceding STATUS cycle and there is only one pusher.
  - Simultaneous push and pop: both occur and fifo_level is unchanged. A push into an empty FIFO is visible on out_valid the next cycle.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Fullness: full = (fifo_level == DEPTH).
  - A pop in the same STATUS cycle does not unblock that cycle; the full decision uses the registered level.
- Arithmetic: ptr is $clog2(NDEV) bits with an explicit compare-to-NDEV-1 wrap, so non-power-of-2 NDEV is supported.
- Ordering: FIFO entries leave in push order. Per device, order equals enter-key order.

Test Plan:
- Reset, then poll_en=1 with all status=0 → dev_a0 stays 1, dev_ack stays 0, ptr cycles 0,1,2,3,0 one step per cycle, out_valid=0.
- Device 2 status=1, data=16'hBEEF → exactly one dev_ack=4'b0100 pulse with dev_a0=0; next cycle out_valid=1, out_dev=2, out_data=16'hBEEF; out_ready=1 pops it, so out_valid=0 and fifo_level=0.
- Devices 0 and 3 ready simultaneously with data 16'h0001 and 16'h0003 → FIFO order is dev0 then dev3; the two acks are 4 cycles apart (STATUS/DATA/STATUS/STATUS/STATUS/DATA pattern).
- out_ready=0, all devices repeatedly ready → fifo_level reaches 4 and the scheduler stalls in STATUS with no acks. Raise out_ready for one cycle → level drops to 3, then exactly one more ack, and level returns to 4.
- Pop coincident with push at level 2 → level stays 2 and the head entry advances correctly.
- Assert rst_n=0 during a DATA cycle → all outputs return immediately to reset values and fifo_level=0. poll_en=0 mid-run → the scheduler finishes the current DATA cycle, then parks in IDLE with dev_a0=1.

Source files
------------

// File: rtl/switchbank_poll_sched_if.sv
// Bus bundle for the switchbank polling scheduler: device read/ack lines and CPU drain port.
// master = scheduler side, slave = devices/CPU side.
interface switchbank_poll_sched_if #(
    parameter int NDEV  = 4,
    parameter int DEPTH = 4,
    parameter int W     = 16
);
    localparam int DW = $clog2(NDEV);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NDEV*W-1:0] dev_rdata;
    logic              dev_a0;
    logic [NDEV-1:0]   dev_ack;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [DW-1:0]     out_dev;
    logic              out_ready;
    logic [LW-1:0]     fifo_level;

    modport master (
        input  dev_rdata, out_ready,
        output dev_a0, dev_ack, out_valid, out_data, out_dev, fifo_level
    );

    modport slave (
        output dev_rdata, out_ready,
        input  dev_a0, dev_ack, out_valid, out_data, out_dev, fifo_level
    );
endinterface

// File: rtl/switchbank_poll_sched.sv
// Round-robin status poller for NDEV switchbank peripherals; ready data is acked and
// queued with its device index in a show-ahead FIFO drained by the CPU.
module switchbank_poll_sched #(
    parameter int NDEV  = 4,
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    poll_en,
    switchbank_poll_sched_if.master bus
);
    localparam int PW = $clog2(NDEV);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATUS,
        S_DATA
    } state_t;

    typedef struct packed {
        logic [PW-1:0] dev;
        logic [W-1:0]  data;
    } entry_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] ptr_inc;
    logic [W-1:0]  cur_word;
    logic          st;
    logic          full;
    logic          push;
    logic          pop;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    always_comb begin
        cur_word = bus.dev_rdata[int'(ptr_q)*W +: W];
        st       = cur_word[0];
        ptr_inc  = (ptr_q == PW'(NDEV-1)) ? '0 : ptr_q + 1'b1;
        // Fullness uses the registered level; a same-cycle pop does not unblock STATUS.
        full     = (level_q == LW'(DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bus.dev_a0  = 1'b1;
        bus.dev_ack = '0;
        case (state_q)
            S_IDLE: begin
                if (poll_en) state_d = S_STATUS;
            end
            S_STATUS: begin
                if (!poll_en) begin
                    state_d = S_IDLE;
                end else if (st) begin
                    if (!full) state_d = S_DATA;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            S_DATA: begin
                bus.dev_a0          = 1'b0;
                bus.dev_ack[ptr_q]  = 1'b1;
                ptr_d               = ptr_inc;
                state_d             = poll_en ? S_STATUS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Space for the DATA push was already guaranteed by the preceding STATUS check.
    assign push = (state_q == S_DATA);
    assign pop  = (level_q != '0) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{dev: ptr_q, data: cur_word};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_comb begin
        bus.out_valid  = (level_q != '0);
        bus.out_data   = mem_q[rd_ptr_q].data;
        bus.out_dev    = mem_q[rd_ptr_q].dev;
        bus.fifo_level = level_q;
    end
endmodule

// File: tb/tb_switchbank_poll_sched.sv
// Randomized bench for switchbank_poll_sched: device models plus a queue-based scheduler model.
module tb_switchbank_poll_sched;
    localparam int NDEV  = 4;
    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic poll_en = 1'b0;

    always #5 clk = ~clk;

    switchbank_poll_sched_if #(.NDEV(NDEV), .DEPTH(DEPTH), .W(W)) bus_if ();

    switchbank_poll_sched #(.NDEV(NDEV), .DEPTH(DEPTH), .W(W)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .poll_en(poll_en),
        .bus    (bus_if)
    );

    // Peripheral models: status word in bit 0 when a0=1, data word when a0=0.
    logic [NDEV-1:0] dev_st = '0;
    logic [W-1:0]    dev_dat [NDEV];
    logic            rearm = 1'b0;

    always_comb begin
        bus_if.dev_rdata = '0;
        for (int i = 0; i < NDEV; i++)
            bus_if.dev_rdata[i*W +: W] = bus_if.dev_a0 ? {{(W-1){1'b0}}, dev_st[i]} : dev_dat[i];
    end

    // Scheduler model: running/visiting flags, visit pointer, FIFO as a queue.
    typedef struct {
        int         dev;
        logic [W-1:0] data;
    } ent_t;
    ent_t mq[$];
    bit   m_run  = 1'b0;
    bit   m_data = 1'b0;
    int   m_ptr  = 0;

    int vectors = 0;
    int miscompares = 0;
    logic [NDEV-1:0] obs_ack;
    logic            obs_a0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a0", 64'(bus_if.dev_a0), 64'(!m_data));
        chk("ack", 64'(bus_if.dev_ack), m_data ? (64'd1 << m_ptr) : 64'd0);
        chk("valid", 64'(bus_if.out_valid), 64'(mq.size() != 0));
        chk("level", 64'(bus_if.fifo_level), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_dev", 64'(bus_if.out_dev), 64'(mq[0].dev));
            chk("head_data", 64'(bus_if.out_data), 64'(mq[0].data));
        end
    endtask

    function automatic int wrap(input int p);
        return (p == NDEV-1) ? 0 : p + 1;
    endfunction

    task automatic model_edge();
        int  lvl = mq.size();
        bit  pop = (lvl != 0) && bus_if.out_ready;
        if (m_data) begin
            mq.push_back('{dev: m_ptr, data: dev_dat[m_ptr]});
            m_ptr  = wrap(m_ptr);
            m_data = 1'b0;
            m_run  = poll_en;
        end else if (m_run) begin
            if (!poll_en) m_run = 1'b0;
            else if (dev_st[m_ptr]) begin
                if (lvl < DEPTH) m_data = 1'b1;
            end else m_ptr = wrap(m_ptr);
        end else if (poll_en) begin
            m_run = 1'b1;
        end
        if (pop) void'(mq.pop_front());
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 1'b0; m_data = 1'b0; m_ptr = 0;
    endtask

    // One clock: compare at the falling edge, apply inputs, then advance models after the rising edge.
    task automatic step(input logic pe, input logic rdy);
        @(negedge clk);
        check_model();
        obs_ack = bus_if.dev_ack;
        obs_a0  = bus_if.dev_a0;
        poll_en = pe;
        bus_if.out_ready = rdy;
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < NDEV; i++) begin
            if (obs_ack[i] && !obs_a0) begin
                dev_st[i] = 1'b0;
                if (rearm) begin
                    dev_st[i]  = 1'b1;
                    dev_dat[i] = W'($urandom);
                end
            end
        end
    endtask

    task automatic set_ready(input int i, input logic [W-1:0] d);
        dev_st[i]  = 1'b1;
        dev_dat[i] = d;
    endtask

    task automatic wait_data(input logic rdy, input int limit);
        int n = 0;
        while (bus_if.dev_ack == '0 && n < limit) begin
            step(1'b1, rdy);
            n++;
        end
        chk("wait_data", 64'(bus_if.dev_ack != '0), 64'd1);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (bus_if.fifo_level != '0 && n < limit) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk("drain", 64'(bus_if.fifo_level), 64'd0);
    endtask

    initial begin
        int n;
        int acks;
        int t_first, t_second;
        logic [NDEV-1:0] first_ack, second_ack;
        logic [$clog2(NDEV)-1:0] head_before;

        for (int i = 0; i < NDEV; i++) dev_dat[i] = '0;
        bus_if.out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a0", 64'(bus_if.dev_a0), 64'd1);
        chk("rst_ack", 64'(bus_if.dev_ack), 64'd0);
        chk("rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_level", 64'(bus_if.fifo_level), 64'd0);
        rst_n = 1'b1;

        // Idle polling with nothing ready
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // Single device 2 transfer
        set_ready(2, 16'hBEEF);
        n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
        end while (obs_ack == '0 && n < 2*NDEV + 2);
        chk("d2_ack", 64'(obs_ack), 64'b0100);
        chk("d2_a0", 64'(obs_a0), 64'd0);
        chk("d2_valid", 64'(bus_if.out_valid), 64'd1);
        chk("d2_dev", 64'(bus_if.out_dev), 64'd2);
        chk("d2_data", 64'(bus_if.out_data), 64'hBEEF);
        step(1'b1, 1'b1);
        chk("d2_popped_valid", 64'(bus_if.out_valid), 64'd0);
        chk("d2_popped_level", 64'(bus_if.fifo_level), 64'd0);

        // Devices 0 and 3 together, starting from the device-0 visit
        n = 0;
        while (!(m_run && !m_data && m_ptr == 0) && n < 20) begin
            step(1'b1, 1'b0);
            n++;
        end
        set_ready(0, 16'h0001);
        set_ready(3, 16'h0003);
        t_first = -1; t_second = -1; first_ack = '0; second_ack = '0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0);
            if (obs_ack != '0) begin
                if (t_first < 0) begin t_first = c; first_ack = obs_ack; end
                else if (t_second < 0) begin t_second = c; second_ack = obs_ack; end
            end
        end
        chk("pair_first_ack", 64'(first_ack), 64'b0001);
        chk("pair_second_ack", 64'(second_ack), 64'b1000);
        chk("pair_spacing", 64'(t_second - t_first), 64'd4);
        chk("pair_head0_dev", 64'(bus_if.out_dev), 64'd0);
        chk("pair_head0_data", 64'(bus_if.out_data), 64'h0001);
        step(1'b1, 1'b1);
        chk("pair_head1_dev", 64'(bus_if.out_dev), 64'd3);
        chk("pair_head1_data", 64'(bus_if.out_data), 64'h0003);
        step(1'b1, 1'b1);
        chk("pair_empty", 64'(bus_if.fifo_level), 64'd0);

        // Fill to full and stall
        rearm = 1'b1;
        for (int i = 0; i < NDEV; i++) set_ready(i, W'($urandom));
        for (int c = 0; c < 40; c++) step(1'b1, 1'b0);
        chk("full_level", 64'(bus_if.fifo_level), 64'd4);
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0);
            if (obs_ack != '0) acks++;
        end
        chk("full_stall_acks", 64'(acks), 64'd0);
        step(1'b1, 1'b1);
        chk("full_pop_level", 64'(bus_if.fifo_level), 64'd3);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0);
            if (obs_ack != '0) acks++;
        end
        chk("full_refill_acks", 64'(acks), 64'd1);
        chk("full_refill_level", 64'(bus_if.fifo_level), 64'd4);

        // Push coincident with pop at level 2
        rearm = 1'b0;
        dev_st = '0;
        drain(20);
        set_ready(1, 16'h1111);
        set_ready(2, 16'h2222);
        n = 0;
        while (bus_if.fifo_level != 2 && n < 20) begin
            step(1'b1, 1'b0);
            n++;
        end
        set_ready(3, 16'h3333);
        wait_data(1'b0, 20);
        chk("pp_level_before", 64'(bus_if.fifo_level), 64'd2);
        head_before = bus_if.out_dev;
        step(1'b1, 1'b1);
        chk("pp_level_after", 64'(bus_if.fifo_level), 64'd2);
        chk("pp_head_moved", 64'(bus_if.out_dev == head_before), 64'd0);
        drain(20);

        // Reset during a DATA cycle
        set_ready(0, 16'hA5A5);
        wait_data(1'b1, 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a0", 64'(bus_if.dev_a0), 64'd1);
        chk("mid_rst_ack", 64'(bus_if.dev_ack), 64'd0);
        chk("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_level", 64'(bus_if.fifo_level), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // poll_en falls during DATA: transfer completes, then the scheduler parks
        wait_data(1'b0, 20);
        step(1'b0, 1'b0);
        chk("park_a0", 64'(bus_if.dev_a0), 64'd1);
        chk("park_level", 64'(bus_if.fifo_level), 64'd1);
        set_ready(1, 16'h7777);
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0);
            if (obs_ack != '0 || !obs_a0) acks++;
        end
        chk("park_no_acks", 64'(acks), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NDEV; i++)
                if (!dev_st[i] && ($urandom % 4) == 0) set_ready(i, W'($urandom));
            step(($urandom % 8) != 0, ($urandom % 3) != 0);
        end
        dev_st = '0;
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
